axi2apb_bridge: RTL

- Downstream consumer of the AXI slave's simple request interface (req_valid/addr/write/wdata/wstrb/bytes/last).
- Converts each 64-bit request into one or two 32-bit APB transfers and returns a single response: rdata plus an error flag.
- Sits between the generic AXI slave front-end and an APB peripheral cluster (UART, GPIO, timers).

---
 rtl/axi2apb_bridge_pkg.sv | 59 +++++
 rtl/types_amba_pkg.sv | 8 +
 rtl/axi2apb_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/axi2apb_bridge_pkg.sv
// Types and reset value for the AXI-request to APB bridge register set.
package axi2apb_bridge_pkg;

    import types_amba_pkg::*;

    // Sized for the largest supported timeout; the count saturates at
    // timeout_cycles, so only the low $clog2(timeout_cycles+1) bits ever toggle
    // and synthesis trims the rest. A fixed width also keeps timeout_cycles=0
    // legal (it would otherwise need a zero-width counter).
    localparam int TMO_CNT_BITS = 32;

    // One-hot bridge states.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SETUP  = 4'b0010,
        ST_ACCESS = 4'b0100,
        ST_RESP   = 4'b1000
    } axi2apb_state_t;

    // Full register set; also serves as the debug view of the FSM.
    typedef struct packed {
        axi2apb_state_t                     state;
        logic                               half_cnt;    // 0 = low word, 1 = high word
        logic                               two_halves;  // both words go out on APB
        logic                               skip_lo;
        logic                               skip_hi;
        logic [CFG_SYSBUS_ADDR_BITS-1:0]    addr;
        logic                               write;
        logic [CFG_SYSBUS_DATA_BITS-1:0]    wdata;
        logic [CFG_SYSBUS_DATA_BYTES-1:0]   wstrb;
        logic [7:0]                         bytes;
        logic [31:0]                        rdata_lo;
        logic [31:0]                        rdata_hi;
        logic                               err_acc;
        logic [TMO_CNT_BITS-1:0]            tmo_cnt;
        logic                               psel;
        logic                               penable;
    } axi2apb_bridge_registers;

    localparam axi2apb_bridge_registers axi2apb_bridge_r_reset = '{
        state:      ST_IDLE,
        half_cnt:   1'b0,
        two_halves: 1'b0,
        skip_lo:    1'b0,
        skip_hi:    1'b0,
        addr:       '0,
        write:      1'b0,
        wdata:      '0,
        wstrb:      '0,
        bytes:      '0,
        rdata_lo:   '0,
        rdata_hi:   '0,
        err_acc:    1'b0,
        tmo_cnt:    '0,
        psel:       1'b0,
        penable:    1'b0
    };

endpackage

// File: rtl/types_amba_pkg.sv
// System-bus geometry shared by the AMBA front-ends and bridges.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

endpackage

// File: rtl/axi2apb_bridge.sv
// Splits one 64-bit system-bus request into one or two 32-bit APB transfers
// and returns a single response (replicated or concatenated read data + error).
//
// Handshakes: a request is taken on a cycle where i_req_valid and o_req_ready
// are both high; a response is retired on a cycle where o_resp_valid and
// i_resp_ready are both high. o_resp_valid and its payload stay stable until
// retired, and o_req_ready is low from acceptance until the response retires.
module axi2apb_bridge
    import types_amba_pkg::*, axi2apb_bridge_pkg::*;
#(
    parameter int abits          = 32,
    parameter int timeout_cycles = 1023
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_req_valid,
    output logic                              o_req_ready,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]   i_req_addr,
    input  logic                              i_req_write,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]   i_req_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0]  i_req_wstrb,
    input  logic [7:0]                        i_req_bytes,
    input  logic                              i_req_last,
    output logic                              o_resp_valid,
    input  logic                              i_resp_ready,
    output logic [63:0]                       o_resp_rdata,
    output logic                              o_resp_err,
    output logic                              o_psel,
    output logic                              o_penable,
    output logic                              o_pwrite,
    output logic [abits-1:0]                  o_paddr,
    output logic [31:0]                       o_pwdata,
    output logic [3:0]                        o_pstrb,
    output logic [2:0]                        o_pprot,
    input  logic                              i_pready,
    input  logic                              i_pslverr,
    input  logic [31:0]                       i_prdata
);

    localparam bit                      TMO_EN    = (timeout_cycles != 0);
    localparam logic [TMO_CNT_BITS-1:0] TMO_LIMIT = TMO_CNT_BITS'(timeout_cycles);

    axi2apb_bridge_registers r;
    axi2apb_bridge_registers v;

    logic lane_hi;
    logic lo_used;
    logic hi_used;
    logic lo_skip;
    logic hi_skip;

    // Next-state and register update for the whole bridge.
    always_comb begin
        v       = r;
        lane_hi = i_req_addr[2];
        lo_used = (i_req_bytes == 8'd8) || !lane_hi;
        hi_used = (i_req_bytes == 8'd8) || lane_hi;
        // A write half with no strobes has nothing to do on the bus.
        lo_skip = !lo_used || (i_req_write && (i_req_wstrb[3:0] == 4'h0));
        hi_skip = !hi_used || (i_req_write && (i_req_wstrb[7:4] == 4'h0));

        case (r.state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    v.addr       = i_req_addr;
                    v.write      = i_req_write;
                    v.wdata      = i_req_wdata;
                    v.wstrb      = i_req_wstrb;
                    v.bytes      = i_req_bytes;
                    v.rdata_lo   = '0;
                    v.rdata_hi   = '0;
                    v.err_acc    = 1'b0;
                    v.tmo_cnt    = '0;
                    v.skip_lo    = lo_skip;
                    v.skip_hi    = hi_skip;
                    v.two_halves = !lo_skip && !hi_skip;
                    v.half_cnt   = lo_skip;
                    if (lo_skip && hi_skip) begin
                        v.state = ST_RESP;
                    end else begin
                        v.state   = ST_SETUP;
                        v.psel    = 1'b1;
                        v.penable = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                v.state   = ST_ACCESS;
                v.penable = 1'b1;
                v.tmo_cnt = '0;
            end
            ST_ACCESS: begin
                if (i_pready) begin
                    if (r.half_cnt) begin
                        v.rdata_hi = i_prdata;
                    end else begin
                        v.rdata_lo = i_prdata;
                    end
                    v.err_acc = r.err_acc | i_pslverr;
                    if (!r.half_cnt && r.two_halves) begin
                        v.half_cnt = 1'b1;
                        v.state    = ST_SETUP;
                        v.penable  = 1'b0;
                    end else begin
                        v.state   = ST_RESP;
                        v.psel    = 1'b0;
                        v.penable = 1'b0;
                    end
                end else if (TMO_EN && ((r.tmo_cnt + TMO_CNT_BITS'(1)) == TMO_LIMIT)) begin
                    // Peripheral never answered: abandon this and any pending half.
                    v.err_acc = 1'b1;
                    v.state   = ST_RESP;
                    v.psel    = 1'b0;
                    v.penable = 1'b0;
                end else if (TMO_EN && (r.tmo_cnt != TMO_LIMIT)) begin
                    v.tmo_cnt = r.tmo_cnt + TMO_CNT_BITS'(1);
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    v.state = ST_IDLE;
                end
            end
            default: begin
                v = axi2apb_bridge_r_reset;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r <= axi2apb_bridge_r_reset;
        end else begin
            r <= v;
        end
    end

    assign o_req_ready  = (r.state == ST_IDLE);
    assign o_resp_valid = (r.state == ST_RESP);
    assign o_resp_err   = o_resp_valid & r.err_acc;
    assign o_resp_rdata = !o_resp_valid        ? 64'h0 :
                          (r.bytes == 8'd8)    ? {r.rdata_hi, r.rdata_lo} :
                          r.addr[2]            ? {r.rdata_hi, r.rdata_hi} :
                                                 {r.rdata_lo, r.rdata_lo};

    assign o_psel    = r.psel;
    assign o_penable = r.penable;
    assign o_pwrite  = r.write;
    assign o_paddr   = {r.addr[abits-1:3], r.half_cnt, 2'b00};
    assign o_pwdata  = r.half_cnt ? r.wdata[63:32] : r.wdata[31:0];
    assign o_pstrb   = !r.write ? 4'h0 : (r.half_cnt ? r.wstrb[7:4] : r.wstrb[3:0]);
    assign o_pprot   = 3'b000;

    // Bits carried in the register set or port list that the datapath never reads.
    logic unused_bits;
    assign unused_bits = ^{i_req_last, r.addr[CFG_SYSBUS_ADDR_BITS-1:abits],
                           r.addr[1:0], r.skip_lo, r.skip_hi};

endmodule
